// File: rtl/handshake_data_to_ctrl_if.sv
// Handshake bundle for the data-to-control converter: data-token input channel
// plus dataless control-token output channel.
interface handshake_data_to_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] ins;
    logic                  ins_valid;
    logic                  ins_ready;
    logic                  outs_valid;
    logic                  outs_ready;

    modport master (
        output ins, ins_valid, outs_ready,
        input  ins_ready, outs_valid
    );

    modport slave (
        input  ins, ins_valid, outs_ready,
        output ins_ready, outs_valid
    );
endinterface

// File: rtl/handshake_data_to_ctrl.sv
// Consumes data tokens and emits one dataless control token per accepted token
// through an opaque elastic buffer; tracks a sticky mismatch flag and a saturating count.
module handshake_data_to_ctrl #(
    parameter int unsigned     DATA_WIDTH = 32,
    parameter longint unsigned EXPECTED   = 64'd1,
    parameter int unsigned     DEPTH      = 2,
    parameter int unsigned     CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    handshake_data_to_ctrl_if.slave hs,
    output logic                 mismatch,
    output logic [CNT_WIDTH-1:0] token_count
);

    localparam int unsigned           OCC_W   = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0]      OCC_MAX = OCC_W'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] EXP_V   = DATA_WIDTH'(EXPECTED);

    if (DEPTH < 1 || DEPTH > 15) begin : g_bad_depth
        $error("handshake_data_to_ctrl: DEPTH must be within 1..15");
    end

    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_nxt;
    logic             push;
    logic             pop;

    // Ready/valid come from occupancy alone, so neither side sees a combinational path
    assign hs.ins_ready  = (occ < OCC_MAX) & rst;
    assign hs.outs_valid = (occ != '0);

    assign push = hs.ins_valid & hs.ins_ready;
    assign pop  = hs.outs_valid & hs.outs_ready;

    always_comb begin
        occ_nxt = occ;
        if (push && !pop) begin
            occ_nxt = occ + OCC_W'(1);
        end else if (pop && !push) begin
            occ_nxt = occ - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ <= '0;
        end else begin
            occ <= occ_nxt;
        end
    end

    // Debug observers: they watch accepted tokens but never influence flow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mismatch    <= 1'b0;
            token_count <= '0;
        end else if (push) begin
            if (hs.ins != EXP_V) begin
                mismatch <= 1'b1;
            end
            if (token_count != {CNT_WIDTH{1'b1}}) begin
                token_count <= token_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_handshake_data_to_ctrl.sv
// Scoreboard bench for handshake_data_to_ctrl: directed vectors on a DEPTH=2 instance
// plus a CNT_WIDTH=4 instance for counter saturation.
module tb_handshake_data_to_ctrl;

    logic clk;
    logic rst_n;

    handshake_data_to_ctrl_if #(.DATA_WIDTH(32)) bus ();
    handshake_data_to_ctrl_if #(.DATA_WIDTH(32)) s_bus ();

    logic        mismatch;
    logic [15:0] token_count;
    logic        s_mismatch;
    logic [3:0]  s_count;

    handshake_data_to_ctrl #(
        .DATA_WIDTH(32), .EXPECTED(64'd1), .DEPTH(2), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst_n), .hs(bus),
        .mismatch(mismatch), .token_count(token_count)
    );

    handshake_data_to_ctrl #(
        .DATA_WIDTH(32), .EXPECTED(64'd1), .DEPTH(2), .CNT_WIDTH(4)
    ) dut_sat (
        .clk(clk), .rst(rst_n), .hs(s_bus),
        .mismatch(s_mismatch), .token_count(s_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int pops = 0;
    int valid_cyc = 0;
    int ready_low = 0;
    int cycle = 0;
    int sbq[$];

    int m_occ = 0;
    int m_cnt = 0;
    int m_mis = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cycle++;

    // Monitor and reference model, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ins_ready", bus.ins_ready, 0);
            chk("rst_outs_valid", bus.outs_valid, 0);
            chk("rst_mismatch", mismatch, 0);
            chk("rst_token_count", token_count, 0);
            m_occ = 0;
            m_cnt = 0;
            m_mis = 0;
            sbq.delete();
        end else begin
            chk("ins_ready", bus.ins_ready, (m_occ < 2) ? 1 : 0);
            chk("outs_valid", bus.outs_valid, (m_occ != 0) ? 1 : 0);
            chk("mismatch", mismatch, m_mis);
            chk("token_count", token_count, m_cnt);
            chk("occ_range", (dut.occ <= 2'd2) ? 1 : 0, 1);
            if (bus.outs_valid) valid_cyc++;
            if (!bus.ins_ready) ready_low++;
            if (bus.outs_valid && bus.outs_ready) begin
                chk("sb_token_pending", (sbq.size() != 0) ? 1 : 0, 1);
                if (sbq.size() != 0) void'(sbq.pop_front());
                pops++;
            end
            if (bus.ins_valid && bus.ins_ready) sbq.push_back(cycle + 1);
            begin
                bit mp;
                bit mq;
                mp = bus.ins_valid && (m_occ < 2);
                mq = bus.outs_ready && (m_occ != 0);
                if (mp) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (bus.ins != 32'd1) m_mis = 1;
                end
                m_occ = m_occ + int'(mp) - int'(mq);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish, expected finish before 50000");
        $fatal(1, "timeout");
    end

    int p0;
    int v0;
    int r0;
    logic [31:0] mis_vals [3];
    int          mis_exp  [3];

    initial begin
        rst_n = 1'b0;
        bus.ins = '0;   bus.ins_valid = 1'b0;   bus.outs_ready = 1'b0;
        s_bus.ins = '0; s_bus.ins_valid = 1'b0; s_bus.outs_ready = 1'b0;
        mis_vals[0] = 32'd1; mis_vals[1] = 32'd5; mis_vals[2] = 32'd1;
        mis_exp[0]  = 0;     mis_exp[1]  = 1;     mis_exp[2]  = 1;

        #2;
        chk("reset_ins_ready", bus.ins_ready, 0);
        chk("reset_outs_valid", bus.outs_valid, 0);
        chk("reset_token_count", token_count, 0);
        step(2);
        rst_n = 1'b1;
        #1;
        chk("post_reset_ins_ready", bus.ins_ready, 1);

        // Single token
        p0 = pops; v0 = valid_cyc;
        bus.ins = 32'd1; bus.ins_valid = 1'b1; bus.outs_ready = 1'b1;
        step(1);
        bus.ins_valid = 1'b0;
        chk("single_outs_valid_after_accept", bus.outs_valid, 1);
        step(3);
        chk("single_pops", pops - p0, 1);
        chk("single_valid_cycles", valid_cyc - v0, 1);
        chk("single_token_count", token_count, 1);
        chk("single_mismatch", mismatch, 0);

        // Fill and backpressure
        bus.outs_ready = 1'b0; bus.ins_valid = 1'b1; bus.ins = 32'd1;
        step(3);
        chk("fill_ins_ready", bus.ins_ready, 0);
        chk("fill_outs_valid", bus.outs_valid, 1);
        chk("fill_occ", dut.occ, 2);
        chk("fill_token_count", token_count, 3);
        p0 = pops;
        bus.outs_ready = 1'b1;
        step(2);
        chk("fill_third_accepted", token_count, 4);
        bus.ins_valid = 1'b0;
        step(1);
        chk("fill_pops", pops - p0, 3);
        chk("fill_drained", bus.outs_valid, 0);

        // Streaming
        p0 = pops; r0 = ready_low;
        bus.ins_valid = 1'b1; bus.outs_ready = 1'b1; bus.ins = 32'd1;
        step(100);
        chk("stream_pops", pops - p0, 99);
        chk("stream_ready_drops", ready_low - r0, 0);
        chk("stream_token_count", token_count, 104);
        bus.ins_valid = 1'b0;
        step(1);
        chk("stream_drained", bus.outs_valid, 0);

        // Mismatch
        p0 = pops;
        bus.outs_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.ins = mis_vals[i]; bus.ins_valid = 1'b1;
            step(1);
            chk("mismatch_after_accept", mismatch, mis_exp[i]);
        end
        bus.ins_valid = 1'b0; bus.ins = 32'd1;
        step(2);
        chk("mismatch_pops", pops - p0, 3);
        chk("mismatch_sticky", mismatch, 1);
        chk("mismatch_token_count", token_count, 107);

        // Reset mid-run with two buffered tokens
        bus.outs_ready = 1'b0; bus.ins_valid = 1'b1; bus.ins = 32'd1;
        step(2);
        bus.ins_valid = 1'b0;
        chk("pre_reset_occ", dut.occ, 2);
        chk("pre_reset_mismatch", mismatch, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outs_valid", bus.outs_valid, 0);
        chk("async_rst_ins_ready", bus.ins_ready, 0);
        chk("async_rst_mismatch", mismatch, 0);
        chk("async_rst_token_count", token_count, 0);
        step(2);
        rst_n = 1'b1;
        p0 = pops;
        bus.ins = 32'd1; bus.ins_valid = 1'b1; bus.outs_ready = 1'b1;
        step(1);
        bus.ins_valid = 1'b0;
        step(3);
        chk("after_reset_pops", pops - p0, 1);
        chk("after_reset_token_count", token_count, 1);
        chk("after_reset_mismatch", mismatch, 0);

        // Saturation on the 4-bit counter instance
        s_bus.ins = 32'd1; s_bus.ins_valid = 1'b1; s_bus.outs_ready = 1'b1;
        step(10);
        chk("sat_count_10", s_count, 10);
        step(10);
        chk("sat_count_20", s_count, 15);
        s_bus.ins_valid = 1'b0;
        step(2);
        chk("sat_count_hold", s_count, 15);
        chk("sat_mismatch", s_mismatch, 0);
        chk("sat_drained", s_bus.outs_valid, 0);

        chk("sb_empty_at_end", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
